// File: rtl/duc_config_sequencer_pkg.sv
// Shared definitions for the DUC configuration sequencer.
// Register offsets, controller states and the queued command layout.
package duc_config_sequencer_pkg;

  localparam int SR_PHASE_INC = 0;
  localparam int SR_SCALE     = 1;
  localparam int SR_RATE      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    WRITE   = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/duc_config_sequencer_cmd_fifo.sv
// Synchronous command FIFO, 40 bits wide, 2**DEPTH_LOG2 deep.
// Pointers carry one extra wrap bit to tell full from empty.
module duc_cmd_fifo
  import duc_config_sequencer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  cmd_t wr_data,
  input  logic wr_en,
  output logic full,
  output cmd_t rd_data,
  input  logic rd_en,
  output logic empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  cmd_t mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic push;
  logic pop;

  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (push && !clr)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/duc_config_sequencer.sv
// Sequences settings writes into one DUC chain, making rate
// changes glitch-safe by quiescing run around the write.
module duc_config_sequencer
  import duc_config_sequencer_pkg::*;
#(
  parameter logic [7:0] BASE            = 8'd0,
  parameter int         FIFO_DEPTH_LOG2 = 2,
  parameter int         FLUSH_CYCLES    = 64,
  parameter int         SETTLE_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        run_in,
  output logic        run_out,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        busy,
  output logic [15:0] rate_chg_cnt
);

  localparam int CW = cnt_width(FLUSH_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] FLUSH_LOAD  = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    RATE_ADDR   = BASE + 8'(SR_RATE);

  state_t        state;
  state_t        state_nxt;
  logic          hold;
  logic          hold_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  cmd_t          cmd_r;
  cmd_t          cmd_nxt;
  logic          is_rate;
  logic          is_rate_nxt;
  logic [15:0]   rcnt_nxt;
  cmd_t          last;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          stb;

  duc_cmd_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .wr_data({cmd_addr, cmd_data}),
    .wr_en  (cmd_valid),
    .full   (full),
    .rd_data(head),
    .rd_en  (pop),
    .empty  (empty)
  );

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    cnt_nxt     = cnt;
    cmd_nxt     = cmd_r;
    is_rate_nxt = is_rate;
    rcnt_nxt    = rate_chg_cnt;
    pop         = 1'b0;
    stb         = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      hold_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop         = 1'b1;
            cmd_nxt     = head;
            is_rate_nxt = head.addr == RATE_ADDR;
            if (head.addr == RATE_ADDR && run_in) begin
              hold_nxt  = 1'b1;
              cnt_nxt   = FLUSH_LOAD;
              state_nxt = QUIESCE;
            end else begin
              state_nxt = WRITE;
            end
          end
        end
        QUIESCE: begin
          if (cnt == '0)
            state_nxt = WRITE;
          else
            cnt_nxt = cnt - 1'b1;
        end
        WRITE: begin
          stb = 1'b1;
          if (is_rate) begin
            cnt_nxt   = SETTLE_LOAD;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            hold_nxt  = 1'b0;
            rcnt_nxt  = rate_chg_cnt + 16'd1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold         <= 1'b0;
      cnt          <= '0;
      cmd_r        <= '0;
      is_rate      <= 1'b0;
      rate_chg_cnt <= '0;
      last         <= '0;
    end else begin
      state        <= state_nxt;
      hold         <= hold_nxt;
      cnt          <= cnt_nxt;
      cmd_r        <= cmd_nxt;
      is_rate      <= is_rate_nxt;
      rate_chg_cnt <= rcnt_nxt;
      if (stb)
        last <= cmd_r;
    end
  end

  // Outputs show the live command while strobing, the last write otherwise.
  assign set_stb   = stb;
  assign set_addr  = stb ? cmd_r.addr : last.addr;
  assign set_data  = stb ? cmd_r.data : last.data;
  assign run_out   = run_in & ~hold;
  assign cmd_ready = ~full;
  assign busy      = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_duc_config_sequencer.sv
// Scoreboard bench for duc_config_sequencer with a queue-level
// reference model of the command schedule.
module tb_duc_config_sequencer;

  localparam int FLUSH  = 64;
  localparam int SETTLE = 4;
  localparam int DEPTH  = 4;
  localparam logic [7:0] RATE = 8'h02;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        run_in = 1'b1;
  logic        run_out;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        busy;
  logic [15:0] rate_chg_cnt;

  duc_config_sequencer #(
    .BASE           (8'h00),
    .FIFO_DEPTH_LOG2(2),
    .FLUSH_CYCLES   (FLUSH),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .run_in      (run_in),
    .run_out     (run_out),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .busy        (busy),
    .rate_chg_cnt(rate_chg_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a command queue plus the schedule of the command
  // being serviced (pos = cycles since pop, wr = write slot, len = span).
  logic [39:0] mq[$];
  logic [39:0] sb[$];
  logic [39:0] m_cmd;
  logic [39:0] m_last = '0;
  logic [39:0] exp_cmd;
  int          pos = -1;
  int          len = 0;
  int          wr = 0;
  logic        m_rate = 1'b0;
  logic        m_hold = 1'b0;
  logic [15:0] m_rcnt = '0;
  bit          push_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      pos = -1;
      m_hold = 1'b0;
      m_rcnt = '0;
    end else if (clr) begin
      mq.delete();
      sb.delete();
      pos = -1;
      m_hold = 1'b0;
    end else begin
      push_ok = cmd_valid && (mq.size() < DEPTH);
      if (pos >= 0) begin
        pos++;
        if (pos == len) begin
          if (m_rate) begin
            m_rcnt = m_rcnt + 16'd1;
            m_hold = 1'b0;
          end
          pos = -1;
        end
      end else if (mq.size() > 0) begin
        m_cmd = mq.pop_front();
        m_rate = m_cmd[39:32] == RATE;
        if (m_rate && run_in) begin
          m_hold = 1'b1;
          wr = FLUSH;
          len = FLUSH + 1 + SETTLE;
        end else if (m_rate) begin
          wr = 0;
          len = 1 + SETTLE;
        end else begin
          wr = 0;
          len = 1;
        end
        pos = 0;
      end
      if (push_ok) begin
        mq.push_back({cmd_addr, cmd_data});
        sb.push_back({cmd_addr, cmd_data});
      end
    end
  end

  // Monitor: compares every output on the falling edge.
  always @(negedge clk) begin
    if (!rst_n)
      m_last = '0;
    check("set_stb", 64'(set_stb), 64'(pos >= 0 && pos == wr && !clr));
    if (set_stb) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stb_unexpected: got addr %0h expected none", set_addr);
      end else begin
        exp_cmd = sb.pop_front();
        check("set_addr", 64'(set_addr), 64'(exp_cmd[39:32]));
        check("set_data", 64'(set_data), 64'(exp_cmd[31:0]));
        m_last = exp_cmd;
      end
    end else begin
      check("addr_hold", 64'(set_addr), 64'(m_last[39:32]));
      check("data_hold", 64'(set_data), 64'(m_last[31:0]));
    end
    check("run_out", 64'(run_out), 64'(run_in & ~m_hold));
    check("busy", 64'(busy), 64'(pos >= 0 || mq.size() > 0));
    check("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
    check("rate_chg_cnt", 64'(rate_chg_cnt), 64'(m_rcnt));
  end

  task automatic drive(input logic v, input logic [7:0] a,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_addr = a;
    cmd_data = d;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      drive(1'b0, cmd_addr, cmd_data);
      if (pos < 0 && mq.size() == 0)
        done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy expected idle within %0d", budget);
    end
  endtask

  task automatic wait_pos(input int target, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (pos == target)
        done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: got %0d expected %0d", pos, target);
    end
  endtask

  logic [7:0] ra;

  initial begin
    run_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(rate_chg_cnt), 64'd0);
    check("rst_run", 64'(run_out), 64'd1);

    // phase write, then rate write with run asserted
    drive(1'b1, 8'h00, 32'h12345678);
    wait_idle(20);
    drive(1'b1, RATE, 32'h304);
    wait_idle(200);

    // rate write while idle
    run_in = 1'b0;
    drive(1'b1, RATE, 32'h0000_0002);
    wait_idle(50);

    // backpressure: rate then five scale writes back-to-back
    run_in = 1'b1;
    drive(1'b1, RATE, 32'hAAAA_0001);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 8'h01, 32'h5C00_0000 + 32'(i));
    wait_idle(300);

    // clear 20 cycles into quiesce with two commands queued
    drive(1'b1, RATE, 32'hDEAD_0003);
    drive(1'b1, 8'h01, 32'h0000_0011);
    drive(1'b1, 8'h00, 32'h0000_0022);
    drive(1'b0, 8'h00, 32'h0);
    wait_pos(20, 100);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_run", 64'(run_out), 64'd1);
    check("clr_ready", 64'(cmd_ready), 64'd1);
    wait_idle(10);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 8'h00;
        1: ra = 8'h01;
        2: ra = RATE;
        default: ra = 8'($urandom_range(3, 255));
      endcase
      if ($urandom_range(0, 15) == 0)
        run_in = ~run_in;
      drive(1'($urandom_range(0, 2) == 0), ra, $urandom);
    end
    wait_idle(500);

    // async reset in the middle of SETTLE
    run_in = 1'b0;
    drive(1'b1, RATE, 32'h0000_0777);
    drive(1'b0, 8'h00, 32'h0);
    wait_pos(2, 20);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_cnt", 64'(rate_chg_cnt), 64'd0);
    check("arst_ready", 64'(cmd_ready), 64'd1);
    check("arst_stb", 64'(set_stb), 64'd0);
    check("arst_addr", 64'(set_addr), 64'd0);
    check("arst_data", 64'(set_data), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_in = 1'b1;
    check("post_rst_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    drive(1'b1, 8'h01, 32'hCAFE_F00D);
    wait_idle(20);
    repeat (2) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
